// File: rtl/inst_packer.sv
// Packs MIPS R/I-type fields into 32-bit words and queues them with sequential byte-address tags.
// Optional: define INST_PACKER_SHAMT_EN to pack in_shamt into bits [10:6] of R-type words.
module inst_packer #(
  parameter int DEPTH     = 4,
  parameter int ADDR_W    = 8,
  parameter int BASE_ADDR = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [5:0]               in_opcode,
  input  logic [4:0]               in_rs,
  input  logic [4:0]               in_rt,
  input  logic [4:0]               in_rd,
  input  logic [4:0]               in_shamt,
  input  logic [5:0]               in_funct,
  input  logic [15:0]              in_imm,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_inst,
  output logic [ADDR_W-1:0]        out_addr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_W-1:0] BASE  = ADDR_W'(BASE_ADDR);
  localparam logic [CNT_W-1:0]  FULL  = CNT_W'(DEPTH);
`ifdef INST_PACKER_SHAMT_EN
  localparam logic [4:0] SHAMT_MASK = 5'h1f;
`else
  localparam logic [4:0] SHAMT_MASK = 5'h00;
`endif

  logic [31:0]       mem_inst [DEPTH];
  logic [ADDR_W-1:0] mem_addr [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0] addr_cnt;
  logic [4:0]        shamt_eff;
  logic [31:0]       packed_word;
  logic              push;
  logic              pop;

  function automatic logic [31:0] pack_word(
    input logic [5:0]  op,
    input logic [4:0]  rs,
    input logic [4:0]  rt,
    input logic [4:0]  rd,
    input logic [4:0]  sh,
    input logic [5:0]  fn,
    input logic [15:0] imm
  );
    if (op == 6'd0) return {op, rs, rt, rd, sh, fn};
    else            return {op, rs, rt, imm};
  endfunction

  assign shamt_eff   = in_shamt & SHAMT_MASK;
  assign packed_word = pack_word(in_opcode, in_rs, in_rt, in_rd, shamt_eff, in_funct, in_imm);

  // Ready/valid depend only on registered occupancy, keeping the two sides decoupled.
  assign in_ready  = (count != FULL);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // Control: pointers, occupancy and address counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= BASE;
    end else if (clr) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      addr_cnt <= BASE;
    end else begin
      if (push) begin
        wr_ptr   <= wr_ptr + PTR_W'(1);
        addr_cnt <= addr_cnt + ADDR_W'(4);
      end
      if (pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Data storage carries no reset; empty-state outputs are masked below instead.
  always_ff @(posedge clk) begin
    if (push && !clr) begin
      mem_inst[wr_ptr] <= packed_word;
      mem_addr[wr_ptr] <= addr_cnt;
    end
  end

  assign out_inst = out_valid ? mem_inst[rd_ptr] : 32'd0;
  assign out_addr = out_valid ? mem_addr[rd_ptr] : addr_cnt;

endmodule

// File: tb/tb_inst_packer.sv
// Self-checking bench for inst_packer: directed scenarios plus randomized traffic against a queue model.
module tb_inst_packer;

  localparam int DEPTH = 4;
`ifdef INST_PACKER_SHAMT_EN
  localparam bit SHAMT_ON = 1'b1;
`else
  localparam bit SHAMT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic clr = 1'b0;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [5:0] op = '0, fn = '0;
  logic [4:0] rs = '0, rt = '0, rd = '0, sh = '0;
  logic [15:0] imm = '0;

  logic        in_ready, out_valid;
  logic [31:0] out_inst;
  logic [7:0]  out_addr;
  logic [2:0]  count;
  logic        in_ready2, out_valid2;
  logic [31:0] out_inst2;
  logic [3:0]  out_addr2;
  logic [2:0]  count2;

  int checks = 0;
  int errors = 0;
  logic [39:0] mq[$];
  int unsigned maddr = 0;

  always #5 clk = ~clk;

  inst_packer #(.DEPTH(DEPTH), .ADDR_W(8), .BASE_ADDR(0)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(sh), .in_funct(fn),
    .in_imm(imm), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
    .out_addr(out_addr), .count(count)
  );

  inst_packer #(.DEPTH(DEPTH), .ADDR_W(4), .BASE_ADDR(0)) dut_narrow (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready2),
    .in_opcode(op), .in_rs(rs), .in_rt(rt), .in_rd(rd), .in_shamt(sh), .in_funct(fn),
    .in_imm(imm), .out_valid(out_valid2), .out_ready(out_ready), .out_inst(out_inst2),
    .out_addr(out_addr2), .count(count2)
  );

  function automatic logic [31:0] exp_pack(input int unsigned o, s, t, d, h, f, i);
    int unsigned w;
    w = o * 32'h0400_0000 + s * 32'h0020_0000 + t * 32'h0001_0000;
    if (o == 0) w = w + d * 2048 + (SHAMT_ON ? h * 64 : 0) + f;
    else        w = w + i;
    return w;
  endfunction

  task automatic set_fields(input logic [5:0] o, input logic [4:0] s, t, d, h,
                            input logic [5:0] f, input logic [15:0] i);
    op = o; rs = s; rt = t; rd = d; sh = h; fn = f; imm = i;
  endtask

  task automatic rand_fields();
    op  = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom);
    rs  = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    sh  = 5'($urandom); fn = 6'($urandom); imm = 16'($urandom);
  endtask

  task automatic model_edge();
    bit pu, po;
    logic [39:0] dummy;
    if (clr) begin
      mq.delete();
      maddr = 0;
    end else begin
      po = out_ready && (mq.size() != 0);
      pu = in_valid && (mq.size() != DEPTH);
      if (po) dummy = mq.pop_front();
      if (pu) begin
        mq.push_back({8'(maddr), exp_pack(op, rs, rt, rd, sh, fn, imm)});
        maddr = (maddr + 4) % 256;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    mq.delete();
    maddr = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++;
    if ({in_ready, out_valid, count, out_inst, out_addr} !== {1'b1, 1'b0, 3'd0, 32'd0, 8'd0}) begin
      errors++;
      $display("FAIL reset_values got rdy=%b vld=%b cnt=%0d inst=%h addr=%h want 1 0 0 0 0",
               in_ready, out_valid, count, out_inst, out_addr);
    end
    do_reset();
  endtask

  task automatic test_rtype_add();
    do_reset();
    set_fields(6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'hABCD);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b1 || out_inst !== 32'h00221820 || out_addr !== 8'h00) begin
      errors++;
      $display("FAIL add_pack got vld=%b inst=%h addr=%h want 1 00221820 00", out_valid, out_inst, out_addr);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_itype();
    do_reset();
    out_ready = 1'b1;
    set_fields(6'h08, 5'd0, 5'd8, 5'd31, 5'd31, 6'h3f, 16'd5);
    in_valid = 1'b1;
    tick();
    set_fields(6'h23, 5'd29, 5'd8, 5'd7, 5'd9, 6'h11, 16'd4);
    #2;
    checks++;
    if (out_inst !== 32'h20080005 || out_addr !== 8'h00) begin
      errors++;
      $display("FAIL addi_pack got inst=%h addr=%h want 20080005 00", out_inst, out_addr);
    end
    tick();
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_inst !== 32'h8FA80004 || out_addr !== 8'h04) begin
      errors++;
      $display("FAIL lw_pack got inst=%h addr=%h want 8fa80004 04", out_inst, out_addr);
    end
    tick();
    #2;
    checks++;
    if (out_valid !== 1'b0 || count !== 3'd0) begin
      errors++;
      $display("FAIL itype_drained got vld=%b cnt=%0d want 0 0", out_valid, count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_shamt();
    logic [31:0] want;
    do_reset();
    want = SHAMT_ON ? 32'h00011100 : 32'h00011000;
    set_fields(6'd0, 5'd0, 5'd1, 5'd2, 5'd4, 6'd0, 16'hFFFF);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_inst !== want) begin
      errors++;
      $display("FAIL sll_shamt got %h want %h", out_inst, want);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_full();
    logic [31:0] want;
    do_reset();
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      set_fields(6'h08, 5'(i), 5'(i + 1), 5'd0, 5'd0, 6'd0, 16'(16'h100 + i));
      #2;
      checks++;
      if (in_ready !== (i < 4)) begin
        errors++;
        $display("FAIL full_in_ready[%0d] got %b want %b", i, in_ready, (i < 4));
      end
      tick();
    end
    in_valid = 1'b0;
    #2;
    checks++;
    if (count !== 3'd4 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_count got cnt=%0d rdy=%b want 4 0", count, in_ready);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      want = exp_pack(8, i, i + 1, 0, 0, 0, 256 + i);
      checks++;
      if (out_valid !== 1'b1 || out_inst !== want || out_addr !== 8'(4 * i)) begin
        errors++;
        $display("FAIL drain[%0d] got vld=%b inst=%h addr=%h want 1 %h %h",
                 i, out_valid, out_inst, out_addr, want, 8'(4 * i));
      end
      tick();
      #2;
    end
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL drain_empty got cnt=%0d vld=%b want 0 0", count, out_valid);
    end
    out_ready = 1'b0;
    in_valid = 1'b1;
    repeat (4) tick();
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    #2;
    checks++;
    if (count !== 3'd3 || in_ready !== 1'b1 || out_addr !== 8'h14) begin
      errors++;
      $display("FAIL full_push_pop got cnt=%0d rdy=%b addr=%h want 3 1 14", count, in_ready, out_addr);
    end
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    #2;
    checks++;
    if (mq.size() != 0 || count !== 3'd0) begin
      errors++;
      $display("FAIL full_refill_drain got cnt=%0d want 0", count);
    end
    out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    logic [3:0] wa [5];
    wa = '{4'h0, 4'h4, 4'h8, 4'hC, 4'h0};
    do_reset();
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      set_fields(6'h08, 5'(k), 5'(k), 5'd0, 5'd0, 6'd0, 16'(k));
      tick();
      #2;
      checks++;
      if (out_valid2 !== 1'b1 || out_addr2 !== wa[k]) begin
        errors++;
        $display("FAIL wrap_addr[%0d] got vld=%b addr=%h want 1 %h", k, out_valid2, out_addr2, wa[k]);
      end
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_clr();
    do_reset();
    in_valid = 1'b1;
    rand_fields(); tick();
    rand_fields(); tick();
    out_ready = 1'b1;
    clr = 1'b1;
    #2;
    checks++;
    if (count !== 3'd2) begin
      errors++;
      $display("FAIL clr_precount got %0d want 2", count);
    end
    tick();
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #2;
    checks++;
    if (count !== 3'd0 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL clr_empty got cnt=%0d vld=%b want 0 0", count, out_valid);
    end
    rand_fields();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_valid !== 1'b1 || out_addr !== 8'h00) begin
      errors++;
      $display("FAIL clr_base_addr got vld=%b addr=%h want 1 00", out_valid, out_addr);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    in_valid = 1'b1;
    repeat (3) begin rand_fields(); tick(); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, count, out_inst, out_addr} !== {1'b1, 1'b0, 3'd0, 32'd0, 8'd0}) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b vld=%b cnt=%0d inst=%h addr=%h want 1 0 0 0 0",
               in_ready, out_valid, count, out_inst, out_addr);
    end
    do_reset();
    in_valid = 1'b1;
    rand_fields();
    tick();
    in_valid = 1'b0;
    #2;
    checks++;
    if (out_addr !== 8'h00 || out_inst !== mq[0][31:0]) begin
      errors++;
      $display("FAIL post_reset_push got inst=%h addr=%h want %h 00", out_inst, out_addr, mq[0][31:0]);
    end
  endtask

  task automatic test_random();
    logic [2:0] ecnt;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      rand_fields();
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ((n / 100) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      clr       = ($urandom_range(0, 49) == 0);
      #2;
      ecnt = 3'(mq.size());
      checks++;
      if (count !== ecnt || in_ready !== (mq.size() != DEPTH) || out_valid !== (mq.size() != 0)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d] got cnt=%0d rdy=%b vld=%b want cnt=%0d", n, count, in_ready, out_valid, ecnt);
      end
      if (mq.size() != 0) begin
        checks++;
        if ({out_addr, out_inst} !== mq[0]) begin
          errors++;
          $display("FAIL rand_head[%0d] got %h/%h want %h/%h", n, out_addr, out_inst, mq[0][39:32], mq[0][31:0]);
        end
      end
      tick();
    end
    clr = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_rtype_add();
    test_itype();
    test_shamt();
    test_full();
    test_wrap();
    test_clr();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/inst_packer.md
# inst_packer

Packs decoded MIPS instruction fields (opcode, rs, rt, rd, shamt, funct, immediate) back into 32-bit R-type and I-type instruction words. This is the inverse of the instruction field splitter. Packed words are buffered in a small FIFO, each tagged with a sequential byte address, so a testbench or boot loader can stream programs into instruction memory through a valid/ready handshake.

## Interface
Parameters:
- DEPTH, 4: FIFO entries; must be a power of two, ≥2.
- ADDR_W, 8: width of the byte-address counter.
- BASE_ADDR, 0: address tag given to the first word after reset or `clr`. Must be a multiple of 4.

Ports:
- clk  in  1  sole clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- clr  in  1  synchronous clear: empties the FIFO and reloads the address counter to BASE_ADDR.
- in_valid  in  1  field set on the in_* ports is valid.
- in_ready  out  1  block can accept a field set.
- in_opcode  in  6  opcode; 0 selects R-type.
- in_rs, in_rt, in_rd  in  5 each  register fields.
- in_shamt  in  5  shift amount; R-type only.
- in_funct  in  6  function code; R-type only.
- in_imm  in  16  immediate or offset; I-type only.
- out_valid  out  1  FIFO head holds a word.
- out_ready  in  1  consumer accepts the head word.
- out_inst  out  32  packed instruction at the FIFO head.
- out_addr  out  ADDR_W  byte address tag of the head word.
- count  out  log2(DEPTH)+1  current FIFO occupancy.

## Operation
- Accept happens when in_valid && in_ready.
  - in_ready = (count != DEPTH). It is based on occupancy only, so no push is allowed while the FIFO is full, even if a pop happens in the same cycle.
- Packing is combinational on the input fields. The packed word is written into the FIFO at accept.
  - R-type (in_opcode == 0): {opcode, rs, rt, rd, shamt, funct}.
  - I-type (any other opcode): {opcode, rs, rt, imm}.
  - Fields that do not belong to the selected format are ignored.
- Address counter:
  - Starts at BASE_ADDR.
  - At each accept, the current counter value is stored alongside the word, then the counter advances by 4.
  - Wraps modulo 2^ADDR_W with no flag.
- Pop happens when out_valid && out_ready; it advances the read pointer.
  - out_valid = (count != 0).
  - out_inst and out_addr show the head entry. Their values are don't-care when out_valid = 0.
- Push and pop in the same cycle when 0 < count < DEPTH: count unchanged, both pointers advance.
- Pop attempted when empty: ignored.
- Push attempted when full: ignored, and neither data nor address counter changes.
- `clr` takes priority over push and pop in the same cycle. After `clr`: count = 0, pointers = 0, address counter = BASE_ADDR.
- Reset (asynchronous, any time, including mid-stream) returns every register to its reset value and discards any buffered words.

## Timing
- Reset values: in_ready = 1, out_valid = 0, count = 0, out_inst = 0, out_addr = BASE_ADDR, internal address counter = BASE_ADDR.
- Latency: a word accepted at edge N appears with out_valid = 1 after edge N when the FIFO was empty (one cycle, registered storage).
- Throughput: one word per cycle in each direction.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.
- count, in_ready and out_valid all update on the same edge as the push or pop that changes them.

## Configuration
- INST_PACKER_SHAMT_EN
  - Defined: in_shamt is packed into bits [10:6] of R-type words.
  - Undefined: bits [10:6] are forced to 0 and in_shamt is unused (the port stays, so the interface does not change).

## Test plan
- Reset, then push add $3,$1,$2 (opcode 0, rs 1, rt 2, rd 3, funct 0x20) -> one cycle later out_valid = 1, out_inst = 0x00221820, out_addr = 0x00.
- Push addi (op 0x08, rs 0, rt 8, imm 5), then lw (op 0x23, rs 29, rt 8, imm 4), with out_ready high -> 0x20080005 @0x00, then 0x8FA80004 @0x04.
- sll (op 0, rt 1, rd 2, shamt 4, funct 0) -> 0x00011100 with INST_PACKER_SHAMT_EN defined, 0x00011000 without it.
- Hold out_ready low and push 5 words -> in_ready drops after the 4th, count = 4, the 5th is not accepted. Then hold out_ready high for 4 cycles -> words drain in order with addresses 0x00, 0x04, 0x08, 0x0C.
- ADDR_W = 4: push 5 words -> the addresses read 0x0, 0x4, 0x8, 0xC, 0x0 (wrap).
- Assert `clr` during a simultaneous push and pop with count = 2 -> next cycle count = 0, out_valid = 0. The next word pushed is tagged BASE_ADDR. Repeat with rst_n pulsed low mid-stream -> all outputs immediately take their reset values.
